// File: rtl/dino_sprite.sv
// dino_sprite: jumping dinosaur sprite for a 640x480 VGA frame.
//
// A frame tick is taken from the falling edge of vs. On each tick the
// GROUND/RISE/FALL state machine moves the sprite along a fixed ballistic
// arc. The pixel output is decoded combinationally from the pixel
// address, so it lines up with the generator's registered address.
//
// Ports:
//   vga_clk     in   pixel clock (25 MHz), sole clock
//   clr         in   synchronous active-high reset
//   row_addr    in   [8:0] current pixel row (0-479)
//   col_addr    in   [9:0] current pixel column (0-639)
//   rdn         in   pixel read strobe, active low (1 = blanking)
//   vs          in   vertical sync, low during the sync pulse
//   jump        in   jump request level, synchronous to vga_clk
//   duck        in   duck request level (used only with DINO_DUCK_EN)
//   px_dinosaur out  1 = dinosaur (black) pixel at row_addr/col_addr
//   dino_y      out  [8:0] registered top row of the sprite
//   airborne    out  registered, 1 while rising or falling
//
// Configuration: define DINO_DUCK_EN to enable the ducking sprite.

module dino_sprite (
    input  logic       vga_clk,
    input  logic       clr,
    input  logic [8:0] row_addr,
    input  logic [9:0] col_addr,
    input  logic       rdn,
    input  logic       vs,
    input  logic       jump,
    input  logic       duck,
    output logic       px_dinosaur,
    output logic [8:0] dino_y,
    output logic       airborne
);

    localparam logic [8:0] GroundY  = 9'd376;
    localparam logic [8:0] LaunchY  = 9'd364;
    localparam logic [3:0] LaunchV  = 4'd11;

    typedef enum logic [1:0] {StGround, StRise, StFall} state_e;

    state_e     state_q, state_d;
    logic [8:0] dino_y_q, dino_y_d;
    logic [3:0] vel_q, vel_d;
    logic       jump_req_q, jump_req_d;
    logic       vs_prev_q;
    logic       tick_q;
    logic       airborne_q;
    logic       launch_req;
    logic [9:0] fall_sum;

    always_ff @(posedge vga_clk) begin
        if (clr) begin
            state_q    <= StGround;
            dino_y_q   <= GroundY;
            vel_q      <= 4'd0;
            jump_req_q <= 1'b0;
            vs_prev_q  <= 1'b1;
            tick_q     <= 1'b0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dino_y_q   <= dino_y_d;
            vel_q      <= vel_d;
            jump_req_q <= jump_req_d;
            vs_prev_q  <= vs;
            // One-cycle pulse following the cycle where vs was seen falling.
            tick_q     <= vs_prev_q & ~vs;
            airborne_q <= (state_d != StGround);
        end
    end

    // A jump level present on the tick cycle itself still counts.
    assign launch_req = jump_req_q | jump;
    assign fall_sum   = {1'b0, dino_y_q} + {6'd0, vel_q};

    always_comb begin
        state_d    = state_q;
        dino_y_d   = dino_y_q;
        vel_d      = vel_q;
        jump_req_d = tick_q ? 1'b0 : launch_req;
        if (tick_q) begin
            unique case (state_q)
                StGround: begin
                    if (launch_req) begin
                        dino_y_d = LaunchY;
                        vel_d    = LaunchV;
                        state_d  = StRise;
                    end
                end
                StRise: begin
                    dino_y_d = dino_y_q - {5'd0, vel_q};
                    // Peak reached: keep vel at 1 so the descent starts slowly.
                    if (vel_q == 4'd1) begin
                        state_d = StFall;
                    end else begin
                        vel_d = vel_q - 4'd1;
                    end
                end
                StFall: begin
                    if (fall_sum >= {1'b0, GroundY}) begin
                        dino_y_d = GroundY;
                        vel_d    = 4'd0;
                        state_d  = StGround;
                    end else begin
                        dino_y_d = fall_sum[8:0];
                        vel_d    = vel_q + 4'd1;
                    end
                end
                default: state_d = StGround;
            endcase
        end
    end

    // Pixel decode; 10-bit rows so dino_y + 23 never wraps.
    logic [9:0] row10, top10;
    logic       in_box, in_eye, stand_px, sprite_px;

    assign row10 = {1'b0, row_addr};
    assign top10 = {1'b0, dino_y_q};

    assign in_box = (col_addr >= 10'd80) && (col_addr <= 10'd99) &&
                    (row10 >= top10) && (row10 <= top10 + 10'd23);
    assign in_eye = (col_addr >= 10'd94) && (col_addr <= 10'd95) &&
                    (row10 >= top10 + 10'd3) && (row10 <= top10 + 10'd4);
    assign stand_px = in_box & ~in_eye;

`ifdef DINO_DUCK_EN
    logic ducking, duck_px;

    // Ducking only applies on the ground; the jump path is untouched.
    assign ducking = (state_q == StGround) && duck;
    assign duck_px = (col_addr >= 10'd80) && (col_addr <= 10'd107) &&
                     (row_addr >= 9'd386) && (row_addr <= 9'd399);
    assign sprite_px = ducking ? duck_px : stand_px;
`else
    logic unused_duck;

    assign unused_duck = duck;
    assign sprite_px   = stand_px;
`endif

    assign px_dinosaur = ~rdn & sprite_px;
    assign dino_y      = dino_y_q;
    assign airborne    = airborne_q;

endmodule

// File: tb/tb_dino_sprite.sv
module tb_dino_sprite;

    logic       vga_clk = 1'b0;
    logic       clr = 1'b1;
    logic [8:0] row_addr = 9'd0;
    logic [9:0] col_addr = 10'd0;
    logic       rdn = 1'b1;
    logic       vs = 1'b1;
    logic       jump = 1'b0;
    logic       duck = 1'b0;
    logic       px_dinosaur;
    logic [8:0] dino_y;
    logic       airborne;

    dino_sprite dut (
        .vga_clk     (vga_clk),
        .clr         (clr),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .rdn         (rdn),
        .vs          (vs),
        .jump        (jump),
        .duck        (duck),
        .px_dinosaur (px_dinosaur),
        .dino_y      (dino_y),
        .airborne    (airborne)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        logic [8:0] y;
        logic       air;
        int         frame;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Trajectory model: 0 ground, 1 rise, 2 fall.
    int m_y, m_vel, m_st;

    function void model_reset();
        m_y   = 376;
        m_vel = 0;
        m_st  = 0;
        sb.delete();
    endfunction

    function void model_tick(input bit req);
        case (m_st)
            0: if (req) begin
                m_y = 364; m_vel = 11; m_st = 1;
            end
            1: begin
                m_y = m_y - m_vel;
                if (m_vel == 1) m_st = 2;
                else m_vel = m_vel - 1;
            end
            default: begin
                if (m_y + m_vel >= 376) begin
                    m_y = 376; m_vel = 0; m_st = 0;
                end else begin
                    m_y = m_y + m_vel; m_vel = m_vel + 1;
                end
            end
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        jump = 1'b0;
        vs = 1'b1;
        cycles(2);
        clr = 1'b0;
        model_reset();
    endtask

    // One short frame: optional one-cycle jump pulse, or jump held, then a
    // vs pulse. Expected post-tick state is pushed to the scoreboard.
    task automatic run_frame(input bit pulse, input bit hold, input int frame);
        exp_t e;
        cycles(1);
        jump = pulse | hold;
        cycles(1);
        jump = hold;
        vs = 1'b0;
        cycles(2);
        vs = 1'b1;
        model_tick(pulse | hold);
        e.y = m_y[8:0];
        e.air = (m_st != 0);
        e.frame = frame;
        sb.push_back(e);
        cycles(2);
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        @(negedge vga_clk);
        n_checks++;
        if (dino_y !== 9'd376 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: dino_y=%0d airborne=%b, want 376/0", dino_y, airborne);
        end
        rdn = 1'b0; row_addr = 9'd376; col_addr = 10'd80; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_px_corner: px=%b want 1", px_dinosaur);
        end
        col_addr = 10'd100; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_px_col100: px=%b want 0", px_dinosaur);
        end
        col_addr = 10'd80; row_addr = 9'd375; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_px_row375: px=%b want 0", px_dinosaur);
        end
        row_addr = 9'd399; col_addr = 10'd99; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_px_bottom: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd400; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_px_row400: px=%b want 0", px_dinosaur);
        end
        row_addr = 9'd376; col_addr = 10'd80; rdn = 1'b1; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_px_blank: px=%b want 0", px_dinosaur);
        end
        rdn = 1'b0;
    endtask

    task automatic test_eye();
        rdn = 1'b0; row_addr = 9'd379; col_addr = 10'd94; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL eye_col94: px=%b want 0", px_dinosaur);
        end
        col_addr = 10'd93; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL eye_col93: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd380; col_addr = 10'd95; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL eye_row380: px=%b want 0", px_dinosaur);
        end
        row_addr = 9'd381; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL eye_row381: px=%b want 1", px_dinosaur);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        do_reset();
        for (int f = 1; f <= 27; f++) begin
            run_frame(f == 1, 1'b0, f);
            @(negedge vga_clk);
            e = sb.pop_front();
            n_checks++;
            if (dino_y !== e.y || airborne !== e.air) begin
                n_fail++;
                $display("FAIL jump_tick%0d: dino_y=%0d airborne=%b, want %0d/%b",
                         e.frame, dino_y, airborne, e.y, e.air);
            end
            if (f == 1 || f == 12 || f == 24) begin
                n_checks++;
                if ((f == 1 && (dino_y !== 9'd364 || airborne !== 1'b1)) ||
                    (f == 12 && (dino_y !== 9'd298 || airborne !== 1'b1)) ||
                    (f == 24 && (dino_y !== 9'd376 || airborne !== 1'b0))) begin
                    n_fail++;
                    $display("FAIL jump_milestone%0d: dino_y=%0d airborne=%b", f, dino_y,
                             airborne);
                end
            end
        end
        // Pixel follows the sprite at its new height.
        do_reset();
        run_frame(1'b1, 1'b0, 1);
        rdn = 1'b0; row_addr = 9'd364; col_addr = 10'd85; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_px_top: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd388; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_px_below: px=%b want 0", px_dinosaur);
        end
        sb.delete();
    endtask

    task automatic test_ignored_pulses();
        exp_t e;
        do_reset();
        for (int f = 1; f <= 25; f++) begin
            run_frame(f <= 23, 1'b0, f);
            @(negedge vga_clk);
            e = sb.pop_front();
            n_checks++;
            if (dino_y !== e.y || airborne !== e.air) begin
                n_fail++;
                $display("FAIL pulses_tick%0d: dino_y=%0d airborne=%b, want %0d/%b",
                         e.frame, dino_y, airborne, e.y, e.air);
            end
        end
    endtask

    task automatic test_held_jump();
        exp_t e;
        do_reset();
        for (int f = 1; f <= 25; f++) begin
            run_frame(1'b0, 1'b1, f);
            @(negedge vga_clk);
            e = sb.pop_front();
            n_checks++;
            if (dino_y !== e.y || airborne !== e.air) begin
                n_fail++;
                $display("FAIL held_tick%0d: dino_y=%0d airborne=%b, want %0d/%b",
                         e.frame, dino_y, airborne, e.y, e.air);
            end
        end
        n_checks++;
        if (dino_y !== 9'd364 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL held_relaunch: dino_y=%0d airborne=%b, want 364/1", dino_y, airborne);
        end
        jump = 1'b0;
    endtask

    task automatic test_reset_mid_jump();
        exp_t e;
        do_reset();
        for (int f = 1; f <= 12; f++) begin
            run_frame(f == 1, 1'b0, f);
        end
        sb.delete();
        @(negedge vga_clk);
        n_checks++;
        if (dino_y !== 9'd298) begin
            n_fail++;
            $display("FAIL midreset_peak: dino_y=%0d want 298", dino_y);
        end
        // Reset also wins over a jump request and a vs edge in the same cycle.
        clr = 1'b1; jump = 1'b1; vs = 1'b0;
        cycles(1);
        n_checks++;
        if (dino_y !== 9'd376 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_edge: dino_y=%0d airborne=%b, want 376/0", dino_y, airborne);
        end
        cycles(2);
        clr = 1'b0; jump = 1'b0; vs = 1'b1;
        model_reset();
        for (int f = 1; f <= 5; f++) begin
            run_frame(f == 4, 1'b0, f);
            @(negedge vga_clk);
            e = sb.pop_front();
            n_checks++;
            if (dino_y !== e.y || airborne !== e.air) begin
                n_fail++;
                $display("FAIL postreset_tick%0d: dino_y=%0d airborne=%b, want %0d/%b",
                         e.frame, dino_y, airborne, e.y, e.air);
            end
        end
    endtask

    task automatic test_duck();
        do_reset();
        duck = 1'b1; rdn = 1'b0;
`ifdef DINO_DUCK_EN
        row_addr = 9'd390; col_addr = 10'd105; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL duck_box: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd380; col_addr = 10'd85; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL duck_above: px=%b want 0", px_dinosaur);
        end
        // Ducking must not block a jump, and is ignored while airborne.
        run_frame(1'b1, 1'b0, 1);
        sb.delete();
        n_checks++;
        if (dino_y !== 9'd364 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL duck_jump: dino_y=%0d airborne=%b, want 364/1", dino_y, airborne);
        end
        row_addr = 9'd370; col_addr = 10'd85; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL duck_air_stand: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd390; col_addr = 10'd105; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL duck_air_box: px=%b want 0", px_dinosaur);
        end
`else
        row_addr = 9'd380; col_addr = 10'd85; #1;
        n_checks++;
        if (px_dinosaur !== 1'b1) begin
            n_fail++;
            $display("FAIL noduck_stand: px=%b want 1", px_dinosaur);
        end
        row_addr = 9'd390; col_addr = 10'd105; #1;
        n_checks++;
        if (px_dinosaur !== 1'b0) begin
            n_fail++;
            $display("FAIL noduck_box: px=%b want 0", px_dinosaur);
        end
`endif
        duck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_eye();
        test_jump();
        test_ignored_pulses();
        test_held_jump();
        test_reset_mid_jump();
        test_duck();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
